// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- memory-mapped seven-segment display controller.
//
// Sits on the MEM-stage store path (MemWr/Addr/data_in) beside data memory.
// It holds three registers:
//   BASE_ADDR+0 RAW  : [7:0] segments, [8+NUM_DIGITS-1:8] digit enables
//   BASE_ADDR+4 HEX  : nibble i = hex value shown on digit i
//   BASE_ADDR+8 CTRL : [0] mode (0 manual, 1 auto), [15:8] dp mask,
//                      [23:16] blank mask, [31:24] blink mask
// Manual mode drives the RAW word straight to the pins.
// Auto mode decodes HEX and scans the digits. Each digit is lit for SCAN_DIV cycles.
//
// Optional feature macro: SEG_BLINK_EN.
// When it is defined, the blink mask is implemented. A phase bit toggles every
// BLINK_DIV full scan rounds. While that bit is set, digits in the blink mask are dark.
// When it is undefined, CTRL[31:24] ignores writes and reads as 0.
//
// Ports:
//   clk      core clock
//   rst      asynchronous active-low reset
//   MemWr    store strobe
//   Addr     byte address
//   data_in  store data
//   data_out combinational readback of the addressed register (0 when not hit)
//   hit      Addr selects one of the three registers
//   leds     segments a..g in [6:0], dp in [7]
//   enable   digit enables, bit i = digit i
// Setting SEG_ACTIVE_LOW inverts leds and enable at the pins.
module seg_scan_ctrl #(
    parameter int          NUM_DIGITS     = 4,
    parameter int          SCAN_DIV       = 50000,
    parameter logic [31:0] BASE_ADDR      = 32'h4000_0010,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter int          BLINK_DIV      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemWr,
    input  logic [31:0]           Addr,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  hit,
    output logic [7:0]            leds,
    output logic [NUM_DIGITS-1:0] enable
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);

    logic [8+NUM_DIGITS-1:0] raw_reg;
    logic [4*NUM_DIGITS-1:0] hex_reg;
    logic                    mode_reg;
    logic [NUM_DIGITS-1:0]   dp_reg;
    logic [NUM_DIGITS-1:0]   blank_reg;
    logic [PW-1:0]           presc_reg;
    logic [IW-1:0]           idx_reg;
    logic [7:0]              leds_reg;
    logic [NUM_DIGITS-1:0]   enable_reg;
    logic [7:0]              leds_next;
    logic [NUM_DIGITS-1:0]   enable_next;
    logic [NUM_DIGITS-1:0]   blink_off;

    logic sel_raw, sel_hex, sel_ctrl;
    logic wr_raw, wr_hex, wr_ctrl;
    logic scan_start;
    logic slot_end;
    logic round_end;

    assign sel_raw  = (Addr == BASE_ADDR);
    assign sel_hex  = (Addr == BASE_ADDR + 32'd4);
    assign sel_ctrl = (Addr == BASE_ADDR + 32'd8);
    assign hit      = sel_raw | sel_hex | sel_ctrl;
    assign wr_raw   = MemWr & sel_raw;
    assign wr_hex   = MemWr & sel_hex;
    assign wr_ctrl  = MemWr & sel_ctrl;

    // Only a manual->auto transition restarts the scan.
    // Rewriting CTRL while already in auto mode keeps the current timing.
    assign scan_start = wr_ctrl & data_in[0] & ~mode_reg;
    assign slot_end   = (presc_reg == PMAX);
    assign round_end  = slot_end & (idx_reg == IMAX);

    logic [3:0] nibble [NUM_DIGITS];
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
        assign nibble[gi] = hex_reg[4*gi +: 4];
    end

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'h3f;  4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5b;  4'h3: hex_to_seg = 7'h4f;
            4'h4: hex_to_seg = 7'h66;  4'h5: hex_to_seg = 7'h6d;
            4'h6: hex_to_seg = 7'h7d;  4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7f;  4'h9: hex_to_seg = 7'h6f;
            4'ha: hex_to_seg = 7'h77;  4'hb: hex_to_seg = 7'h7c;
            4'hc: hex_to_seg = 7'h39;  4'hd: hex_to_seg = 7'h5e;
            4'he: hex_to_seg = 7'h79;  default: hex_to_seg = 7'h71;
        endcase
    endfunction

    // Registers, prescaler and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_reg   <= '0;
            hex_reg   <= '0;
            mode_reg  <= 1'b0;
            dp_reg    <= '0;
            blank_reg <= '0;
            presc_reg <= '0;
            idx_reg   <= '0;
        end else begin
            if (wr_raw)
                raw_reg <= data_in[8+NUM_DIGITS-1:0];
            if (wr_hex)
                hex_reg <= data_in[4*NUM_DIGITS-1:0];
            if (wr_ctrl) begin
                mode_reg  <= data_in[0];
                dp_reg    <= data_in[8 +: NUM_DIGITS];
                blank_reg <= data_in[16 +: NUM_DIGITS];
            end
            if (scan_start) begin
                presc_reg <= '0;
                idx_reg   <= '0;
            end else if (slot_end) begin
                presc_reg <= '0;
                idx_reg   <= (idx_reg == IMAX) ? '0 : idx_reg + 1'b1;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

    logic [NUM_DIGITS-1:0] blink_reg;
    logic [BW-1:0]         round_reg;
    logic                  phase_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_reg <= '0;
            round_reg <= '0;
            phase_reg <= 1'b0;
        end else begin
            if (wr_ctrl)
                blink_reg <= data_in[24 +: NUM_DIGITS];
            if (scan_start) begin
                round_reg <= '0;
                phase_reg <= 1'b0;
            end else if (round_end) begin
                if (round_reg == BMAX) begin
                    round_reg <= '0;
                    phase_reg <= ~phase_reg;
                end else begin
                    round_reg <= round_reg + 1'b1;
                end
            end
        end
    end

    assign blink_off = phase_reg ? blink_reg : '0;
`else
    logic unused_blink;
    assign blink_off    = '0;
    assign unused_blink = round_end ^ (BLINK_DIV != 0);
`endif

    logic unused_data;
    assign unused_data = ^data_in;

    // Next output word, in true (active-high) polarity.
    always_comb begin
        leds_next   = raw_reg[7:0];
        enable_next = raw_reg[8 +: NUM_DIGITS];
        if (mode_reg) begin
            leds_next   = {dp_reg[idx_reg], hex_to_seg(nibble[idx_reg])};
            enable_next = '0;
            if (!blank_reg[idx_reg] && !blink_off[idx_reg])
                enable_next[idx_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds_reg   <= '0;
            enable_reg <= '0;
        end else begin
            leds_reg   <= leds_next;
            enable_reg <= enable_next;
        end
    end

    assign leds   = leds_reg ^ {8{SEG_ACTIVE_LOW}};
    assign enable = enable_reg ^ {NUM_DIGITS{SEG_ACTIVE_LOW}};

    // Readback reflects register state before any write in the same cycle.
    always_comb begin
        data_out = '0;
        if (sel_raw) begin
            data_out[8+NUM_DIGITS-1:0] = raw_reg;
        end else if (sel_hex) begin
            data_out[4*NUM_DIGITS-1:0] = hex_reg;
        end else if (sel_ctrl) begin
            data_out[0]               = mode_reg;
            data_out[8 +: NUM_DIGITS]  = dp_reg;
            data_out[16 +: NUM_DIGITS] = blank_reg;
`ifdef SEG_BLINK_EN
            data_out[24 +: NUM_DIGITS] = blink_reg;
`endif
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Memory-mapped display controller for the MEM stage. It generalises the single-register LED/enable latch to N multiplexed seven-segment digits. Two display modes:
- manual: raw segment/enable word written by the CPU;
- auto: hardware hex decode with timed digit scanning, decimal-point, blank and blink masks.
It sits on the same MemWr/Addr/data_in store path as data memory and drives the board's segment and digit-enable pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
SCAN_DIV, 50000, clk cycles each digit is shown in auto mode (>=1)
BASE_ADDR, 32'h4000_0010, address of RAW register; HEX at +4, CTRL at +8
SEG_ACTIVE_LOW, 0, 1 inverts leds and enable at the outputs
BLINK_DIV, 64, full scan rounds per blink phase (used only with SEG_BLINK_EN)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
MemWr  in  1  store strobe from the pipeline
Addr  in  32  byte address (ALU Result)
data_in  in  32  store data (busB)
data_out  out  32  combinational readback of the addressed register, 0 when not hit
hit  out  1  Addr equals BASE_ADDR, +4 or +8
leds  out  8  segments a..g in [6:0], dp in [7]
enable  out  NUM_DIGITS  digit enables, bit i = digit i

Behaviour:
- Reset (rst=0, asynchronous): RAW, HEX, CTRL, prescaler, digit index, blink state all 0. leds=0, enable=0, or all-ones when SEG_ACTIVE_LOW=1. Reset mid-scan takes effect immediately, with no clock required.
- Registers. Write on posedge clk when MemWr and Addr exactly matches; unmatched addresses are ignored. Unimplemented bits write-ignored and read 0.
  - RAW: [7:0] segments, [8+NUM_DIGITS-1:8] enables.
  - HEX: [4*NUM_DIGITS-1:0], nibble i = digit i.
  - CTRL: [0] MODE (0 manual, 1 auto), [15:8] dp mask, [23:16] blank mask, [31:24] blink mask. Mask fields are NUM_DIGITS wide.
- Manual mode: leds <= RAW[7:0]; enable <= RAW enable field. Outputs are registered, so a write at edge N appears after edge N+1.
- Prescaler and digit index:
  - The prescaler counts 0..SCAN_DIV-1 continuously.
  - At terminal count it returns to 0 and the digit index advances, wrapping NUM_DIGITS-1 -> 0.
  - A CTRL write that changes MODE 0->1 clears the prescaler and index in the same edge, so digit 0 gets a full slot first.
  - A HEX write never disturbs scan timing.
- Auto mode outputs (registered, 1-cycle latency from index/register change):
  - leds[6:0] = hex decode of nibble[index]. Table 0..F: 3f,06,5b,4f,66,6d,7d,07,7f,6f,77,7c,39,5e,79,71.
  - leds[7] = dp mask[index].
  - enable = one-hot(index), forced to 0 when blank mask[index]=1.
- Polarity: inversion is applied after all of the above, in both modes.
- Simultaneous write and terminal count: the write lands, the index advances, and the output of the next edge uses the new register value.
- Read and write of the same register in one cycle: data_out shows the old value.

Optional Feature:
SEG_BLINK_EN.
- Defined:
  - A round counter counts index wraps.
  - Every BLINK_DIV wraps, the blink phase toggles.
  - While phase=1 in auto mode, digits whose blink mask bit is set get enable forced 0.
  - Phase resets to 0 on reset and on MODE 0->1.
- Undefined: CTRL[31:24] is write-ignored and reads 0; no blink counter is instantiated.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, SEG_ACTIVE_LOW=0.
- Reset: hold rst=0 -> leds=0x00, enable=0x0, data_out=0; release rst -> values held.
- Manual write: store 0x0000_0F3F to 0x4000_0010 -> next cycle leds=0x3F, enable=0xF; load 0x4000_0010 -> data_out=0x0000_0F3F, hit=1.
- Auto scan:
  - Stimulus: HEX=0x0000_12AF, then CTRL=0x1.
  - Response: enable 0x1/leds 0x71, 0x2/0x77, 0x4/0x5B, 0x8/0x06, each for exactly 4 cycles, then wraps to 0x1.
- Masks: CTRL=0x0004_0201 with HEX as above -> slot 1 leds=0xF7; slot 2 enable=0x0; slots 0 and 3 unchanged.
- Boundaries:
  - Store to 0x4000_0020 -> no register change, hit=0, data_out=0.
  - Assert rst mid-slot 2 -> outputs 0 immediately; after re-release, MODE=0 and manual zero output.
- Blink (SEG_BLINK_EN, BLINK_DIV=2):
  - Stimulus: CTRL=0x0100_0001.
  - Response: digit 0 enabled for 2 full rounds (32 cycles), dark for the next 2 rounds; digits 1..3 unaffected.
  - Without the macro, CTRL readback is 0x0000_0001.
